axis_pkt_player: RTL and testbench
==================================

AXIS_PKT_PLAYER -- requirements
Module: axis_pkt_player

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 64: stream data width in bits, a multiple of 8.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 14: table address width; depth is 2^ADDR_WIDTH.
REQ-003 SHALL derive KEEP_WIDTH = DATA_WIDTH/8 internally.
REQ-004 SHALL provide these ports:
- tx_mac_aclk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- load_en  in  1  table write strobe
- load_addr  in  ADDR_WIDTH  table write address
- load_ctrl  in  32  ctrl word; [31]=end-of-table, [30]=last beat, [KEEP_WIDTH-1:0]=tkeep
- load_data  in  DATA_WIDTH  data word
- start  in  1  one-cycle run request
- start_addr  in  ADDR_WIDTH  first table entry, sampled on start
- pkt_count  in  16  packets per run, sampled on start; 0 = unlimited
- loop_en  in  1  restart at start_addr on end-of-table, sampled on start
- ipg_cycles  in  8  idle cycles after each tlast, sampled on start
- m_axis_tdata  out  DATA_WIDTH  stream data
- m_axis_tkeep  out  KEEP_WIDTH  byte enables
- m_axis_tlast  out  1  last beat
- m_axis_tvalid  out  1  beat valid
- m_axis_tready  in  1  sink ready
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- pkts_sent  out  16  packets completed in current or last run
- rd_addr  out  ADDR_WIDTH  table entry currently presented or fetched

Function
REQ-005 SHALL hold two synchronous-read tables (32-bit ctrl, DATA_WIDTH data) of depth 2^ADDR_WIDTH; one-cycle read latency.
REQ-006 SHALL write both tables at load_addr on a clock edge with load_en=1 and busy=0; load_en while busy=1 SHALL be ignored.
REQ-007 SHALL implement states IDLE, FETCH, SEND, GAP, FINISH.
REQ-008 IDLE: start=1 -> latch parameters, rd_addr<=start_addr, pkts_sent<=0, busy<=1, go FETCH; start while busy SHALL be ignored.
REQ-009 FETCH: issue read at rd_addr; the following cycle SHALL present the entry (tvalid=1) unless ctrl[31]=1.
REQ-010 SEND: tdata/tkeep/tlast SHALL remain stable while tvalid=1 and tready=0.
REQ-011 Within a packet with tready held high, SHALL sustain one beat per cycle; first beat of a run SHALL assert tvalid 2 cycles after start.
REQ-012 Each handshake SHALL advance rd_addr by 1, wrapping 2^ADDR_WIDTH-1 -> 0.
REQ-013 Handshake with tlast=1 SHALL increment pkts_sent (saturating at 0xFFFF); if pkt_count!=0 and pkts_sent reaches pkt_count -> FINISH, else ipg_cycles>0 -> GAP, else FETCH.
REQ-014 GAP: tvalid=0 for exactly ipg_cycles cycles after the tlast handshake, then FETCH.
REQ-015 Fetched entry with ctrl[31]=1 SHALL NOT be transmitted; loop_en=1 and at least one packet sent since the last pass began -> rd_addr<=start_addr, FETCH; else FINISH.
REQ-016 FINISH: done=1 for one cycle, busy<=0, tvalid=0, IDLE; pkts_sent SHALL hold until next start.
REQ-017 tkeep SHALL be driven from ctrl[KEEP_WIDTH-1:0] unmodified; ctrl bits [29:KEEP_WIDTH] ignored.

Reset
REQ-018 reset=1 SHALL immediately force state IDLE, tvalid=0, tlast=0, tdata=0, tkeep=0, busy=0, done=0, pkts_sent=0, rd_addr=0.
REQ-019 Table contents SHALL NOT be altered by reset; reset mid-packet SHALL drop tvalid without completing the packet.

Verification
REQ-020 Load 3-beat pkt at 0 (tkeep FF,FF,0F; last on beat 3), end marker at 3; start_addr=0, pkt_count=0, tready=1 -> 3 consecutive beats, pkts_sent=1, done pulse, busy=0.
REQ-021 Same table, tready toggling 1/0 each cycle -> tdata stable during stalls, 3 handshakes, identical data order.
REQ-022 Two 2-beat pkts, ipg_cycles=4, pkt_count=2 -> exactly 4 tvalid=0 cycles between packets, done after pkt 2, no marker fetch needed.
REQ-023 loop_en=1, pkt_count=5, one 1-beat pkt before marker -> 5 packets, pkts_sent=5, done; marker at start_addr with loop_en=1 -> done, pkts_sent=0, no tvalid.
REQ-024 start_addr=2^ADDR_WIDTH-1, 2-beat pkt spanning wrap -> beat 2 read from address 0.
REQ-025 reset asserted during beat 2 of 4 -> tvalid=0 same cycle; after release, new start replays packet from beat 1.

Source files
------------

// File: rtl/axis_pkt_player.sv
`default_nettype none
// ============================================================================
// Module      : axis_pkt_player
// Description : Replays packets from a preloaded ctrl/data table onto an
//               AXI4-Stream master, with packet count, looping and gap timing.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pkt_player #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                      tx_mac_aclk,
    input  logic                      reset,
    input  logic                      load_en,
    input  logic [ADDR_WIDTH-1:0]     load_addr,
    input  logic [31:0]               load_ctrl,
    input  logic [DATA_WIDTH-1:0]     load_data,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     start_addr,
    input  logic [15:0]               pkt_count,
    input  logic                      loop_en,
    input  logic [7:0]                ipg_cycles,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               pkts_sent,
    output logic [ADDR_WIDTH-1:0]     rd_addr
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] C_ADDR_ONE = ADDR_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_SEND   = 3'd2,
        S_GAP    = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                  r_state;
    logic [31:0]             ctrl_mem [DEPTH];
    logic [DATA_WIDTH-1:0]   data_mem [DEPTH];

    logic [31:0]             r_ctrl;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [ADDR_WIDTH-1:0]   r_start_addr;
    logic [15:0]             r_pkt_count;
    logic                    r_loop_en;
    logic [7:0]              r_ipg;
    logic [7:0]              r_gap_cnt;
    logic                    r_pass_sent;

    logic                    w_hs;
    logic                    w_rd_en;
    logic [ADDR_WIDTH-1:0]   w_rd_next;
    logic [ADDR_WIDTH-1:0]   w_raddr;
    logic [15:0]             w_pkts_inc;
    logic                    w_unused_ctrl;

    // The read register doubles as the output register, so a stalled beat holds.
    assign m_axis_tdata  = r_data;
    assign m_axis_tkeep  = r_ctrl[KEEP_WIDTH-1:0];
    assign m_axis_tlast  = r_ctrl[30];
    assign m_axis_tvalid = (r_state == S_SEND) && !r_ctrl[31];
    assign w_unused_ctrl = ^r_ctrl[29:KEEP_WIDTH];

    assign w_hs       = m_axis_tvalid && m_axis_tready;
    assign w_rd_next  = rd_addr + C_ADDR_ONE;
    assign w_raddr    = (r_state == S_SEND) ? w_rd_next : rd_addr;
    assign w_rd_en    = (r_state == S_FETCH) || (w_hs && !m_axis_tlast);
    assign w_pkts_inc = (pkts_sent == 16'hFFFF) ? pkts_sent : pkts_sent + 16'd1;

    always_ff @(posedge tx_mac_aclk) begin
        if (load_en && !busy) begin
            ctrl_mem[load_addr] <= load_ctrl;
            data_mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge tx_mac_aclk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ctrl       <= '0;
            r_data       <= '0;
            r_start_addr <= '0;
            r_pkt_count  <= '0;
            r_loop_en    <= 1'b0;
            r_ipg        <= '0;
            r_gap_cnt    <= '0;
            r_pass_sent  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pkts_sent    <= '0;
            rd_addr      <= '0;
        end else begin
            if (w_rd_en) begin
                r_ctrl <= ctrl_mem[w_raddr];
                r_data <= data_mem[w_raddr];
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_start_addr <= start_addr;
                        r_pkt_count  <= pkt_count;
                        r_loop_en    <= loop_en;
                        r_ipg        <= ipg_cycles;
                        r_pass_sent  <= 1'b0;
                        rd_addr      <= start_addr;
                        pkts_sent    <= '0;
                        busy         <= 1'b1;
                        r_state      <= S_FETCH;
                    end
                end
                S_FETCH: r_state <= S_SEND;
                S_SEND: begin
                    if (r_ctrl[31]) begin
                        if (r_loop_en && r_pass_sent) begin
                            rd_addr     <= r_start_addr;
                            r_pass_sent <= 1'b0;
                            r_state     <= S_FETCH;
                        end else begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_FINISH;
                        end
                    end else if (w_hs) begin
                        rd_addr <= w_rd_next;
                        if (m_axis_tlast) begin
                            pkts_sent   <= w_pkts_inc;
                            r_pass_sent <= 1'b1;
                            if (r_pkt_count != 16'd0 && w_pkts_inc == r_pkt_count) begin
                                busy    <= 1'b0;
                                done    <= 1'b1;
                                r_state <= S_FINISH;
                            end else if (r_ipg >= 8'd2) begin
                                // The trailing FETCH cycle is itself idle, so GAP runs ipg-1 cycles.
                                r_gap_cnt <= r_ipg - 8'd2;
                                r_state   <= S_GAP;
                            end else begin
                                r_state <= S_FETCH;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                S_FINISH: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pkt_player
// Description : Directed self-checking bench for axis_pkt_player.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_player;

    localparam int DATA_WIDTH = 64;
    localparam int ADDR_WIDTH = 14;
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                    tx_mac_aclk = 1'b0;
    logic                    reset;
    logic                    load_en;
    logic [ADDR_WIDTH-1:0]   load_addr;
    logic [31:0]             load_ctrl;
    logic [DATA_WIDTH-1:0]   load_data;
    logic                    start;
    logic [ADDR_WIDTH-1:0]   start_addr;
    logic [15:0]             pkt_count;
    logic                    loop_en;
    logic [7:0]              ipg_cycles;
    logic [DATA_WIDTH-1:0]   m_axis_tdata;
    logic [KEEP_WIDTH-1:0]   m_axis_tkeep;
    logic                    m_axis_tlast;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic                    busy;
    logic                    done;
    logic [15:0]             pkts_sent;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    int n_total = 0;
    int n_bad   = 0;

    logic [63:0] q_data [$];
    logic [7:0]  q_keep [$];
    logic        q_last [$];
    int          q_cyc  [$];
    int          done_cnt;

    always #5 tx_mac_aclk = ~tx_mac_aclk;

    axis_pkt_player #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
        .tx_mac_aclk   (tx_mac_aclk),
        .reset         (reset),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_ctrl     (load_ctrl),
        .load_data     (load_data),
        .start         (start),
        .start_addr    (start_addr),
        .pkt_count     (pkt_count),
        .loop_en       (loop_en),
        .ipg_cycles    (ipg_cycles),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .pkts_sent     (pkts_sent),
        .rd_addr       (rd_addr)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [ADDR_WIDTH-1:0] a, input logic [31:0] c, input logic [63:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_ctrl = c;
        load_data = d;
        @(negedge tx_mac_aclk);
        load_en   = 1'b0;
    endtask

    task automatic do_start(input logic [ADDR_WIDTH-1:0] sa, input logic [15:0] cnt,
                            input logic lp, input logic [7:0] ipg);
        start      = 1'b1;
        start_addr = sa;
        pkt_count  = cnt;
        loop_en    = lp;
        ipg_cycles = ipg;
        @(negedge tx_mac_aclk);
        start      = 1'b0;
    endtask

    // mode 0: tready held high; mode 1: tready 1,0,1,0... per cycle
    task automatic capture(input int mode, input int max_cyc);
        logic [63:0] pd;
        logic [7:0]  pk;
        logic        pl;
        logic        stalled;
        bit          fin;
        q_data.delete(); q_keep.delete(); q_last.delete(); q_cyc.delete();
        done_cnt = 0; stalled = 1'b0; fin = 1'b0;
        pd = '0; pk = '0; pl = 1'b0;
        for (int i = 0; i < max_cyc && !fin; i++) begin
            @(negedge tx_mac_aclk);
            if (stalled) begin
                check_val("stall_vld",  m_axis_tvalid, 1);
                check_val("stall_data", m_axis_tdata, pd);
                check_val("stall_keep", m_axis_tkeep, pk);
                check_val("stall_last", m_axis_tlast, pl);
            end
            m_axis_tready = (mode == 0) ? 1'b1 : ((i % 2) == 0);
            if (m_axis_tvalid && m_axis_tready) begin
                q_data.push_back(m_axis_tdata);
                q_keep.push_back(m_axis_tkeep);
                q_last.push_back(m_axis_tlast);
                q_cyc.push_back(i);
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata; pk = m_axis_tkeep; pl = m_axis_tlast;
            if (done) begin
                done_cnt++;
                fin = 1'b1;
                check_val("done_busy", busy, 0);
            end
        end
        if (!fin) check_val("timeout", 0, 1);
        m_axis_tready = 1'b1;
        @(negedge tx_mac_aclk);
        check_val("done_pulse", done, 0);
    endtask

    task automatic check_beats(input string tag, input int n, input logic [63:0] d[8],
                               input logic [7:0] k[8], input logic l[8]);
        check_val({tag, "_nbeats"}, q_data.size(), n);
        for (int i = 0; i < n && i < q_data.size(); i++) begin
            check_val({tag, "_data"}, q_data[i], d[i]);
            check_val({tag, "_keep"}, q_keep[i], k[i]);
            check_val({tag, "_last"}, q_last[i], l[i]);
        end
    endtask

    initial begin
        logic [63:0] ed[8];
        logic [7:0]  ek[8];
        logic        el[8];

        reset = 1'b1; load_en = 1'b0; load_addr = '0; load_ctrl = '0; load_data = '0;
        start = 1'b0; start_addr = '0; pkt_count = '0; loop_en = 1'b0; ipg_cycles = '0;
        m_axis_tready = 1'b1;
        repeat (3) @(negedge tx_mac_aclk);
        check_val("rst_tvalid", m_axis_tvalid, 0);
        check_val("rst_tlast",  m_axis_tlast, 0);
        check_val("rst_tdata",  m_axis_tdata, 0);
        check_val("rst_tkeep",  m_axis_tkeep, 0);
        check_val("rst_busy",   busy, 0);
        check_val("rst_done",   done, 0);
        check_val("rst_pkts",   pkts_sent, 0);
        check_val("rst_rdaddr", rd_addr, 0);
        reset = 1'b0;
        @(negedge tx_mac_aclk);

        // Basic 3-beat packet followed by end marker
        load(14'd0, 32'h0000_00FF, 64'h1111_0000_0000_0001);
        load(14'd1, 32'h0000_00FF, 64'h2222_0000_0000_0002);
        load(14'd2, 32'h4000_000F, 64'h3333_0000_0000_0003);
        load(14'd3, 32'h8000_0000, 64'hDEAD_DEAD_DEAD_DEAD);
        ed = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002, 64'h3333_0000_0000_0003,
               0, 0, 0, 0, 0};
        ek = '{8'hFF, 8'hFF, 8'h0F, 0, 0, 0, 0, 0};
        el = '{1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0};
        do_start(14'd0, 16'd0, 1'b0, 8'd0);
        check_val("t1_busy", busy, 1);
        capture(0, 50);
        check_beats("t1", 3, ed, ek, el);
        if (q_cyc.size() == 3) begin
            check_val("t1_first_cyc", q_cyc[0], 0);
            check_val("t1_b2_cyc",    q_cyc[1], 1);
            check_val("t1_b3_cyc",    q_cyc[2], 2);
        end
        check_val("t1_pkts", pkts_sent, 1);
        check_val("t1_done", done_cnt, 1);
        check_val("t1_busy_end", busy, 0);
        check_val("t1_rdaddr", rd_addr, 3);

        // Same table under backpressure
        do_start(14'd0, 16'd0, 1'b0, 8'd0);
        capture(1, 60);
        check_beats("t2", 3, ed, ek, el);
        check_val("t2_pkts", pkts_sent, 1);

        // Two 2-beat packets with a 4-cycle gap, stop after 2 packets
        load(14'd8,  32'h0000_00FF, 64'hA0);
        load(14'd9,  32'h4000_00FF, 64'hA1);
        load(14'd10, 32'h0000_00FF, 64'hB0);
        load(14'd11, 32'h4000_0001, 64'hB1);
        load(14'd12, 32'h4000_00FF, 64'hEE);
        ed = '{64'hA0, 64'hA1, 64'hB0, 64'hB1, 0, 0, 0, 0};
        ek = '{8'hFF, 8'hFF, 8'hFF, 8'h01, 0, 0, 0, 0};
        el = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0};
        do_start(14'd8, 16'd2, 1'b0, 8'd4);
        capture(0, 60);
        check_beats("t3", 4, ed, ek, el);
        if (q_cyc.size() == 4) check_val("t3_gap", q_cyc[2] - q_cyc[1] - 1, 4);
        check_val("t3_pkts", pkts_sent, 2);
        check_val("t3_done", done_cnt, 1);

        // Looping a 1-beat packet five times
        load(14'd16, 32'h4000_00FF, 64'h55);
        load(14'd17, 32'h8000_0000, 64'h0);
        ed = '{64'h55, 64'h55, 64'h55, 64'h55, 64'h55, 0, 0, 0};
        ek = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0};
        el = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0};
        do_start(14'd16, 16'd5, 1'b1, 8'd0);
        capture(0, 100);
        check_beats("t4", 5, ed, ek, el);
        check_val("t4_pkts", pkts_sent, 5);
        check_val("t4_done", done_cnt, 1);

        // Marker at start_addr with loop_en: nothing sent
        do_start(14'd17, 16'd0, 1'b1, 8'd0);
        capture(0, 30);
        check_val("t5_nbeats", q_data.size(), 0);
        check_val("t5_pkts", pkts_sent, 0);
        check_val("t5_done", done_cnt, 1);

        // Packet spanning the address wrap
        load(14'h3FFF, 32'h0000_00FF, 64'hA1);
        load(14'd0,    32'h4000_0003, 64'hB2);
        ed = '{64'hA1, 64'hB2, 0, 0, 0, 0, 0, 0};
        ek = '{8'hFF, 8'h03, 0, 0, 0, 0, 0, 0};
        el = '{1'b0, 1'b1, 0, 0, 0, 0, 0, 0};
        do_start(14'h3FFF, 16'd1, 1'b0, 8'd0);
        capture(0, 30);
        check_beats("t6", 2, ed, ek, el);
        check_val("t6_pkts", pkts_sent, 1);
        check_val("t6_rdaddr", rd_addr, 1);

        // Reset during beat 2 of a 4-beat packet, then replay
        load(14'd32, 32'h0000_00FF, 64'hC0);
        load(14'd33, 32'h0000_00FF, 64'hC1);
        load(14'd34, 32'h0000_00FF, 64'hC2);
        load(14'd35, 32'h4000_00FF, 64'hC3);
        load(14'd36, 32'h8000_0000, 64'h0);
        do_start(14'd32, 16'd0, 1'b0, 8'd0);
        @(negedge tx_mac_aclk);
        check_val("t7_b1", m_axis_tdata, 64'hC0);
        @(negedge tx_mac_aclk);
        check_val("t7_b2", m_axis_tdata, 64'hC1);
        reset = 1'b1;
        #1;
        check_val("t7_rst_vld",  m_axis_tvalid, 0);
        check_val("t7_rst_busy", busy, 0);
        check_val("t7_rst_addr", rd_addr, 0);
        @(negedge tx_mac_aclk);
        reset = 1'b0;
        @(negedge tx_mac_aclk);
        ed = '{64'hC0, 64'hC1, 64'hC2, 64'hC3, 0, 0, 0, 0};
        ek = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 0};
        el = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0};
        do_start(14'd32, 16'd0, 1'b0, 8'd0);
        capture(0, 40);
        check_beats("t7", 4, ed, ek, el);
        check_val("t7_pkts", pkts_sent, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
